// File: rtl/nco_pkg.sv
// Shared types and defaults for the NCO frequency-sweep controller.
package nco_pkg;

  localparam int PHASE_ACC_BITS_DEF = 20;
  localparam int DWELL_BITS_DEF     = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DWELL  = 2'd1,
    ST_STEP   = 2'd2,
    ST_FINISH = 2'd3
  } sweep_state_e;

  typedef enum logic [1:0] {
    SINGLE   = 2'd0,
    REPEAT   = 2'd1,
    TRIANGLE = 2'd2
  } sweep_mode_e;

  // Mode code 3 is an alias of single-shot.
  function automatic sweep_mode_e decode_mode(input logic [1:0] code);
    case (code)
      2'd1:    decode_mode = REPEAT;
      2'd2:    decode_mode = TRIANGLE;
      default: decode_mode = SINGLE;
    endcase
  endfunction

endpackage

// File: rtl/nco_sweep_step.sv
// Next sweep value: current value moved one step toward stop, clamped at stop.
// Direction is implied by where stop lies relative to the current value.
module nco_sweep_step
  import nco_pkg::*;
#(
  parameter int PHASE_ACC_BITS = PHASE_ACC_BITS_DEF
) (
  input  logic [PHASE_ACC_BITS-1:0] cur_i,
  input  logic [PHASE_ACC_BITS-1:0] stop_i,
  input  logic [PHASE_ACC_BITS-1:0] step_i,
  output logic [PHASE_ACC_BITS-1:0] nxt_o,
  output logic                      at_stop_o
);

  logic [PHASE_ACC_BITS:0] sum_w;
  logic [PHASE_ACC_BITS:0] diff_w;
  logic                    up_w;

  // One extra bit keeps the add/sub from wrapping; the clamp then compares safely.
  always_comb begin
    up_w   = (stop_i >= cur_i);
    sum_w  = {1'b0, cur_i} + {1'b0, step_i};
    diff_w = {1'b0, cur_i} - {1'b0, step_i};
    if (up_w) begin
      nxt_o = (sum_w >= {1'b0, stop_i}) ? stop_i : sum_w[PHASE_ACC_BITS-1:0];
    end else begin
      nxt_o = (diff_w[PHASE_ACC_BITS] || (diff_w[PHASE_ACC_BITS-1:0] <= stop_i))
              ? stop_i : diff_w[PHASE_ACC_BITS-1:0];
    end
    // A zero step can never reach stop, so it ends the leg immediately.
    at_stop_o = (cur_i == stop_i) || (step_i == '0);
  end

endmodule

// File: rtl/nco_sweep_ctrl.sv
// Sweep controller: steps the NCO phase increment from start to stop,
// holding each value for a programmable dwell, in single/repeat/triangle modes.
module nco_sweep_ctrl
  import nco_pkg::*;
#(
  parameter int PHASE_ACC_BITS = PHASE_ACC_BITS_DEF,
  parameter int DWELL_BITS     = DWELL_BITS_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [PHASE_ACC_BITS-1:0] cfg_start_inc,
  input  logic [PHASE_ACC_BITS-1:0] cfg_stop_inc,
  input  logic [PHASE_ACC_BITS-1:0] cfg_step,
  input  logic [DWELL_BITS-1:0]     cfg_dwell,
  input  logic [1:0]                cfg_mode,
  input  logic                      start,
  input  logic                      abort,
  output logic [PHASE_ACC_BITS-1:0] phase_inc,
  output logic                      busy,
  output logic                      done,
  output logic [15:0]               sweep_cnt
);

  sweep_state_e              state_q, state_d;
  sweep_mode_e               mode_q, mode_d;
  logic [PHASE_ACC_BITS-1:0] start_q, start_d;
  logic [PHASE_ACC_BITS-1:0] stop_q, stop_d;
  logic [PHASE_ACC_BITS-1:0] step_q, step_d;
  logic [DWELL_BITS-1:0]     dwell_q, dwell_d;
  logic [DWELL_BITS-1:0]     cnt_q, cnt_d;
  logic [PHASE_ACC_BITS-1:0] phase_q, phase_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  logic [15:0]               swcnt_q, swcnt_d;

  logic [PHASE_ACC_BITS-1:0] nxt_w;
  logic                      at_stop_w;

  function automatic logic [15:0] sat_inc(input logic [15:0] c);
    sat_inc = (c == 16'hFFFF) ? c : c + 16'd1;
  endfunction

  function automatic logic [DWELL_BITS-1:0] dwell_eff(input logic [DWELL_BITS-1:0] d);
    dwell_eff = (d == '0) ? DWELL_BITS'(1) : d;
  endfunction

  nco_sweep_step #(.PHASE_ACC_BITS(PHASE_ACC_BITS)) u_step (
    .cur_i     (phase_q),
    .stop_i    (stop_q),
    .step_i    (step_q),
    .nxt_o     (nxt_w),
    .at_stop_o (at_stop_w)
  );

  // Next-state and datapath updates; STEP is the first cycle of a fresh value,
  // so the new value is loaded on the expiring edge and no cycle is lost.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    start_d = start_q;
    stop_d  = stop_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    swcnt_d = swcnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d  = decode_mode(cfg_mode);
          start_d = cfg_start_inc;
          stop_d  = cfg_stop_inc;
          step_d  = cfg_step;
          dwell_d = dwell_eff(cfg_dwell);
          cnt_d   = dwell_eff(cfg_dwell) - DWELL_BITS'(1);
          phase_d = cfg_start_inc;
          busy_d  = 1'b1;
          swcnt_d = '0;
          state_d = ST_DWELL;
        end
      end
      ST_DWELL, ST_STEP: begin
        if (cnt_q != '0) begin
          cnt_d   = cnt_q - DWELL_BITS'(1);
          state_d = ST_DWELL;
        end else if (at_stop_w) begin
          swcnt_d = sat_inc(swcnt_q);
          cnt_d   = dwell_q - DWELL_BITS'(1);
          state_d = ST_STEP;
          case (mode_q)
            REPEAT:   phase_d = start_q;
            TRIANGLE: begin
              // Degenerate leg (zero step or start == stop): swap and hold.
              start_d = stop_q;
              stop_d  = start_q;
            end
            default: begin
              busy_d  = 1'b0;
              done_d  = 1'b1;
              state_d = ST_FINISH;
            end
          endcase
        end else begin
          phase_d = nxt_w;
          cnt_d   = dwell_q - DWELL_BITS'(1);
          state_d = ST_STEP;
          // Triangle turns around on arrival so the endpoint gets one dwell only.
          if ((mode_q == TRIANGLE) && (nxt_w == stop_q)) begin
            start_d = stop_q;
            stop_d  = start_q;
            swcnt_d = sat_inc(swcnt_q);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort beats everything except reset, including a same-cycle start.
    if (abort) begin
      state_d = ST_IDLE;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      phase_d = phase_q;
      swcnt_d = swcnt_q;
      cnt_d   = cnt_q;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      mode_q  <= SINGLE;
      start_q <= '0;
      stop_q  <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      cnt_q   <= '0;
      phase_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      swcnt_q <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      start_q <= start_d;
      stop_q  <= stop_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      swcnt_q <= swcnt_d;
    end
  end

  assign phase_inc = phase_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign sweep_cnt = swcnt_q;

endmodule
